// File: rtl/rv_pkg.sv
// Shared RV32I encoding constants and the request class encoding.
// Used by the instruction encoder and by the main decoder tests.
package rv_pkg;

    typedef enum logic [2:0] {
        CLS_LW    = 3'd0,
        CLS_ITYPE = 3'd1,
        CLS_RTYPE = 3'd2,
        CLS_SW    = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_JAL   = 3'd5
    } cls_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    // Branch and jump offsets are in half-words, so bit 0 must be clear.
    function automatic logic needs_even_imm(input logic [2:0] cls);
        return (cls == CLS_BEQ) || (cls == CLS_JAL);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer.
// Maps a request class and its fields to a 32-bit word plus an illegal flag.
module instr_pack
    import rv_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [20:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Place each class's fields; unused fields stay zero.
    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        case (cls)
            CLS_LW: begin
                word = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
            end
            CLS_ITYPE: begin
                word = {imm[11:0], rs1, funct3, rd, OP_IMM};
            end
            CLS_RTYPE: begin
                word = {1'b0, funct7b5, 5'b00000,
                        rs2, rs1, funct3, rd, OP_OP};
            end
            CLS_SW: begin
                word = {imm[11:5], rs2, rs1, F3_SW,
                        imm[4:0], OP_STORE};
            end
            CLS_BEQ: begin
                word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                        imm[4:1], imm[11], OP_BRANCH};
            end
            CLS_JAL: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12],
                        rd, OP_JAL};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (needs_even_imm(cls) && imm[0]) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts encode requests and streams RV32I words
// into instruction memory during a start-initiated load session.
module instr_encoder
    import rv_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_class,
    input  logic        in_last,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [20:0] imm,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [10:0] count,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [10:0] DEPTH_C = 11'(DEPTH);

    state_e      state;
    state_e      state_nx;
    logic [31:0] word;
    logic        illegal;
    logic        accept;
    logic        fills;

    instr_pack u_pack (
        .cls      (in_class),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .imm      (imm),
        .word     (word),
        .illegal  (illegal)
    );

    // The word count doubles as the write pointer.
    assign in_ready = (state == ST_LOAD) && (count < DEPTH_C) && !start;
    assign accept   = in_valid && in_ready;
    assign fills    = !illegal && (count + 11'd1 == DEPTH_C);
    assign busy     = (state == ST_LOAD);
    assign done     = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: start wins; a session ends on last or on full memory.
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = ST_LOAD;
        end else if (accept && (in_last || fills)) begin
            state_nx = ST_DONE;
        end
    end

    // Write strobe, address/data registers, word count and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            count     <= 11'd0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            if (start) begin
                count <= 11'd0;
            end else if (accept) begin
                if (illegal) begin
                    err <= 1'b1;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= {19'd0, count, 2'b00};
                    mem_wdata <= word;
                    count     <= count + 11'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases with literal
// expectations plus randomized traffic against a behavioural model.
module tb_instr_encoder;

    localparam int DA = 64;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [2:0]  in_class;
    logic        in_last;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [20:0] imm;

    logic        rdy_a, we_a, busy_a, done_a, err_a;
    logic [31:0] addr_a, wdata_a;
    logic [10:0] cnt_a;
    logic        rdy_b, we_b, busy_b, done_b, err_b;
    logic [31:0] addr_b, wdata_b;
    logic [10:0] cnt_b;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(rdy_a),
        .in_class(in_class), .in_last(in_last),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7b5(funct7b5), .imm(imm),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .count(cnt_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    instr_encoder #(.DEPTH(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(rdy_b),
        .in_class(in_class), .in_last(in_last),
        .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7b5(funct7b5), .imm(imm),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .count(cnt_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    // Model session: st 0=idle 1=load 2=done.
    typedef struct {
        int          st;
        int          cnt;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } mdl_t;

    mdl_t ma = '{0, 0, 1'b0, 32'd0, 32'd0, 1'b0};
    mdl_t mb = '{0, 0, 1'b0, 32'd0, 32'd0, 1'b0};

    function automatic logic [31:0] bits(logic [31:0] v, int lo, int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    // Encoded word built field by field from the ISA layout.
    function automatic logic [31:0] enc(int c);
        logic [31:0] i;
        logic [31:0] w;
        i = 32'(imm);
        w = (32'(rs1) << 15);
        case (c)
            0: w = w | (bits(i, 0, 12) << 20) | (32'd2 << 12)
                     | (32'(rd) << 7) | 32'h03;
            1: w = w | (bits(i, 0, 12) << 20) | (32'(funct3) << 12)
                     | (32'(rd) << 7) | 32'h13;
            2: w = w | (32'(funct7b5) << 30) | (32'(rs2) << 20)
                     | (32'(funct3) << 12) | (32'(rd) << 7) | 32'h33;
            3: w = w | (bits(i, 5, 7) << 25) | (32'(rs2) << 20)
                     | (32'd2 << 12) | (bits(i, 0, 5) << 7) | 32'h23;
            4: w = w | (bits(i, 12, 1) << 31) | (bits(i, 5, 6) << 25)
                     | (32'(rs2) << 20) | (bits(i, 1, 4) << 8)
                     | (bits(i, 11, 1) << 7) | 32'h63;
            default: w = (bits(i, 20, 1) << 31) | (bits(i, 1, 10) << 21)
                     | (bits(i, 11, 1) << 20) | (bits(i, 12, 8) << 12)
                     | (32'(rd) << 7) | 32'h6F;
        endcase
        return w;
    endfunction

    function automatic mdl_t step(mdl_t m, int depth);
        mdl_t n;
        int   c;
        bit   legal;
        n = m;
        n.we = 1'b0;
        n.err = 1'b0;
        c = int'(in_class);
        if (start) begin
            n.st = 1;
            n.cnt = 0;
        end else if (m.st == 1 && in_valid && m.cnt < depth) begin
            legal = (c <= 5) && !((c == 4 || c == 5) && imm[0]);
            if (legal) begin
                n.we = 1'b1;
                n.addr = 32'(4 * m.cnt);
                n.wdata = enc(c);
                n.cnt = m.cnt + 1;
            end else begin
                n.err = 1'b1;
            end
            if (in_last || n.cnt == depth) n.st = 2;
        end
        return n;
    endfunction

    function automatic mdl_t mreset();
        return '{0, 0, 1'b0, 32'd0, 32'd0, 1'b0};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = mreset();
            mb = mreset();
        end else begin
            ma = step(ma, DA);
            mb = step(mb, DB);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    function automatic logic mrdy(mdl_t m, int depth);
        return (m.st == 1) && (m.cnt < depth) && !start;
    endfunction

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("a_we", 32'(we_a), 32'(ma.we));
        chk("a_addr", addr_a, ma.addr);
        chk("a_wdata", wdata_a, ma.wdata);
        chk("a_count", 32'(cnt_a), 32'(ma.cnt));
        chk("a_busy", 32'(busy_a), 32'(ma.st == 1));
        chk("a_done", 32'(done_a), 32'(ma.st == 2));
        chk("a_err", 32'(err_a), 32'(ma.err));
        chk("a_ready", 32'(rdy_a), 32'(mrdy(ma, DA)));
        chk("b_we", 32'(we_b), 32'(mb.we));
        chk("b_addr", addr_b, mb.addr);
        chk("b_wdata", wdata_b, mb.wdata);
        chk("b_count", 32'(cnt_b), 32'(mb.cnt));
        chk("b_busy", 32'(busy_b), 32'(mb.st == 1));
        chk("b_done", 32'(done_b), 32'(mb.st == 2));
        chk("b_err", 32'(err_b), 32'(mb.err));
        chk("b_ready", 32'(rdy_b), 32'(mrdy(mb, DB)));
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic set_req(logic [2:0] c, logic [4:0] d, logic [4:0] s1,
                           logic [4:0] s2, logic [2:0] f3,
                           logic [20:0] im, logic last);
        in_valid = 1'b1;
        in_class = c;
        rd = d;
        rs1 = s1;
        rs2 = s2;
        funct3 = f3;
        funct7b5 = 1'b0;
        imm = im;
        in_last = last;
    endtask

    task automatic req(logic [2:0] c, logic [4:0] d, logic [4:0] s1,
                       logic [4:0] s2, logic [2:0] f3,
                       logic [20:0] im, logic last);
        set_req(c, d, s1, s2, f3, im, last);
        cyc();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_class = 3'd0;
        rd = 5'd0;
        rs1 = 5'd0;
        rs2 = 5'd0;
        funct3 = 3'd0;
        funct7b5 = 1'b0;
        imm = 21'd0;
        repeat (2) cyc();

        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_addr", addr_a, 32'd0);
        chk("rst_wdata", wdata_a, 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        chk("rst_ready", 32'(rdy_a), 32'd0);

        rst_n = 1'b1;
        set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 21'd5, 1'b0);
        repeat (3) cyc();
        in_valid = 1'b0;
        chk("idle_busy", 32'(busy_a), 32'd0);
        chk("idle_we", 32'(we_a), 32'd0);

        do_start();
        req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 21'd5, 1'b0);
        chk("addi_we", 32'(we_a), 32'd1);
        chk("addi_addr", addr_a, 32'd0);
        chk("addi_word", wdata_a, 32'h00500093);

        do_start();
        req(3'd3, 5'd0, 5'd2, 5'd3, 3'd0, 21'd8, 1'b0);
        chk("sw_word", wdata_a, 32'h00312423);
        chk("sw_addr", addr_a, 32'd0);
        req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 21'h1FFFFC, 1'b1);
        chk("beq_word", wdata_a, 32'hFE208EE3);
        chk("beq_addr", addr_a, 32'd4);
        chk("beq_done", 32'(done_a), 32'd1);
        chk("beq_count", 32'(cnt_a), 32'd2);

        do_start();
        req(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 21'd2048, 1'b0);
        chk("jal_word", wdata_a, 32'h001000EF);
        req(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 21'd3, 1'b0);
        chk("jal_odd_err", 32'(err_a), 32'd1);
        chk("jal_odd_we", 32'(we_a), 32'd0);
        chk("jal_odd_count", 32'(cnt_a), 32'd1);
        req(3'd7, 5'd1, 5'd0, 5'd0, 3'd0, 21'd0, 1'b0);
        chk("illegal_err", 32'(err_a), 32'd1);

        do_start();
        for (int i = 0; i < 6; i++) begin
            set_req(3'd1, 5'(i + 1), 5'd2, 5'd0, 3'd0, 21'(i), 1'b0);
            cyc();
            if (i == 3) begin
                chk("full_addr", addr_b, 32'd12);
                chk("full_ready", 32'(rdy_b), 32'd0);
                chk("full_done", 32'(done_b), 32'd1);
                chk("full_count", 32'(cnt_b), 32'd4);
            end
        end
        in_valid = 1'b0;

        do_start();
        req(3'd0, 5'd4, 5'd5, 5'd0, 3'd0, 21'd16, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_cancel_we", 32'(we_a), 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_we", 32'(we_a), 32'd0);
        chk("post_rst_busy", 32'(busy_a), 32'd0);

        do_start();
        for (int i = 0; i < 3; i++) begin
            req(3'd2, 5'd3, 5'd4, 5'(i), 3'd7, 21'd0, 1'b0);
        end
        chk("restart_pre", 32'(cnt_a), 32'd3);
        do_start();
        req(3'd1, 5'd9, 5'd9, 5'd0, 3'd4, 21'd100, 1'b0);
        chk("restart_addr", addr_a, 32'd0);
        chk("restart_count", 32'(cnt_a), 32'd1);

        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            start = ($urandom_range(0, 14) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 9) in_class = 3'($urandom_range(0, 5));
            else in_class = 3'($urandom_range(6, 7));
            in_last = ($urandom_range(0, 11) == 0);
            rd = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            funct3 = 3'($urandom);
            funct7b5 = 1'($urandom);
            imm = 21'($urandom);
            if ($urandom_range(0, 4) != 0) imm[0] = 1'b0;
            cyc();
        end
        rst_n = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        repeat (3) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
